// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: enable polarities and default widths.
package regfile_mp_pkg;

   localparam int DataWDef = 32;
   localparam int AddrWDef = 5;

   localparam logic [DataWDef-1:0] ZeroWord = '0;

   localparam logic RstEnable   = 1'b0;
   localparam logic WriteEnable = 1'b1;
   localparam logic ReadEnable  = 1'b1;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: write-through bypass with highest-index priority,
// then zero-register and busy qualification.
module regfile_rd_port
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W   = DataWDef,
   parameter int ADDR_W   = AddrWDef,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     rst_n,
   input  logic                     re_i,
   input  logic [ADDR_W-1:0]        raddr_i,
   input  logic [NUM_WR-1:0]        we_i,
   input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
   input  logic [NUM_WR*DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0]        regData_i,
   input  logic                     busyBit_i,
   output logic [DATA_W-1:0]        rdata_o,
   output logic                     rbusy_o
);

   // Ascending scan so the highest-index matching writer overrides lower ones.
   always_comb begin
      rdata_o = '0;
      rbusy_o = 1'b0;
      if (rst_n != RstEnable && re_i == ReadEnable &&
          !(ZERO_REG != 0 && raddr_i == '0)) begin
         rdata_o = regData_i;
         rbusy_o = busyBit_i;
         for (int k = 0; k < NUM_WR; k++) begin
            if (we_i[k] == WriteEnable && waddr_i[k*ADDR_W +: ADDR_W] == raddr_i) begin
               rdata_o = wdata_i[k*DATA_W +: DATA_W];
               rbusy_o = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port MIPS32 register file with write-through bypass and a per-register
// pending-write scoreboard for RAW hazard detection in a dual-issue pipeline.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W   = DataWDef,
   parameter int ADDR_W   = AddrWDef,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_WR-1:0]        we_i,
   input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
   input  logic [NUM_WR*DATA_W-1:0] wdata_i,
   input  logic [NUM_RD-1:0]        re_i,
   input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
   output logic [NUM_RD*DATA_W-1:0] rdata_o,
   output logic [NUM_RD-1:0]        rbusy_o,
   input  logic                     alloc_en_i,
   input  logic [ADDR_W-1:0]        alloc_addr_i,
   input  logic                     flush_i,
   output logic [(1<<ADDR_W)-1:0]   busy_vec_o
);

   localparam int Depth = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [Depth];
   logic [DATA_W-1:0] regs_d [Depth];
   logic [Depth-1:0]  busy_q;
   logic [Depth-1:0]  busy_d;

   // Ordering matters: flush, then write completions, then allocation, so a newer
   // producer allocated this cycle keeps its destination busy.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (flush_i) begin
         busy_d = '0;
      end
      for (int k = 0; k < NUM_WR; k++) begin
         if (we_i[k] == WriteEnable) begin
            if (!(ZERO_REG != 0 && waddr_i[k*ADDR_W +: ADDR_W] == '0)) begin
               regs_d[waddr_i[k*ADDR_W +: ADDR_W]] = wdata_i[k*DATA_W +: DATA_W];
            end
            busy_d[waddr_i[k*ADDR_W +: ADDR_W]] = 1'b0;
         end
      end
      if (alloc_en_i && !(ZERO_REG != 0 && alloc_addr_i == '0)) begin
         busy_d[alloc_addr_i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (rst_n == RstEnable) begin
         for (int i = 0; i < Depth; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign busy_vec_o = busy_q;

   for (genvar i = 0; i < NUM_RD; i++) begin : gRdPort
      regfile_rd_port #(
         .DATA_W  (DATA_W),
         .ADDR_W  (ADDR_W),
         .NUM_WR  (NUM_WR),
         .ZERO_REG(ZERO_REG)
      ) uRdPort (
         .rst_n    (rst_n),
         .re_i     (re_i[i]),
         .raddr_i  (raddr_i[i*ADDR_W +: ADDR_W]),
         .we_i     (we_i),
         .waddr_i  (waddr_i),
         .wdata_i  (wdata_i),
         .regData_i(regs_q[raddr_i[i*ADDR_W +: ADDR_W]]),
         .busyBit_i(busy_q[raddr_i[i*ADDR_W +: ADDR_W]]),
         .rdata_o  (rdata_o[i*DATA_W +: DATA_W]),
         .rbusy_o  (rbusy_o[i])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised plus directed scoreboard bench for regfile_mp against an array-based
// reference model of register contents and pending writes.
module tb_regfile_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int NW = 2;

   logic             clk;
   logic             rst_n;
   logic [NW-1:0]    we;
   logic [NW*AW-1:0] waddr;
   logic [NW*DW-1:0] wdata;
   logic [NR-1:0]    re;
   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata;
   logic [NR-1:0]    rbusy;
   logic             allocEn;
   logic [AW-1:0]    allocAddr;
   logic             flush;
   logic [31:0]      busyVec;

   typedef struct {
      logic [NR*DW-1:0] rdata;
      logic [NR-1:0]    rbusy;
      logic [31:0]      busyVec;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] mRegs [32];
   logic [31:0] mBusy;
   int          nChecks = 0;
   int          nFail   = 0;

   regfile_mp dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .we_i        (we),
      .waddr_i     (waddr),
      .wdata_i     (wdata),
      .re_i        (re),
      .raddr_i     (raddr),
      .rdata_o     (rdata),
      .rbusy_o     (rbusy),
      .alloc_en_i  (allocEn),
      .alloc_addr_i(allocAddr),
      .flush_i     (flush),
      .busy_vec_o  (busyVec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic void modelReset();
      for (int a = 0; a < 32; a++) mRegs[a] = '0;
      mBusy = '0;
   endfunction

   // Drives one cycle just after the edge, queues what the reads must show this
   // cycle, then advances the model past the coming edge.
   task automatic applyStimulus(input logic [NW-1:0] weV, input logic [NW*AW-1:0] waV,
                                input logic [NW*DW-1:0] wdV, input logic [NR-1:0] reV,
                                input logic [NR*AW-1:0] raV, input logic alV,
                                input logic [AW-1:0] aaV, input logic flV);
      exp_t        e;
      logic [AW-1:0] a;
      @(posedge clk);
      #1;
      we = weV; waddr = waV; wdata = wdV; re = reV; raddr = raV;
      allocEn = alV; allocAddr = aaV; flush = flV;
      e.busyVec = mBusy;
      for (int i = 0; i < NR; i++) begin
         a = raV[i*AW +: AW];
         e.rdata[i*DW +: DW] = '0;
         e.rbusy[i] = 1'b0;
         if (reV[i] && a != 0) begin
            e.rdata[i*DW +: DW] = mRegs[a];
            e.rbusy[i] = mBusy[a];
            for (int k = NW-1; k >= 0; k--) begin
               if (weV[k] && waV[k*AW +: AW] == a) begin
                  e.rdata[i*DW +: DW] = wdV[k*DW +: DW];
                  e.rbusy[i] = 1'b0;
                  break;
               end
            end
         end
      end
      expQ.push_back(e);
      for (int k = 0; k < NW; k++)
         if (weV[k] && waV[k*AW +: AW] != 0) mRegs[waV[k*AW +: AW]] = wdV[k*DW +: DW];
      if (flV) mBusy = '0;
      for (int k = 0; k < NW; k++)
         if (weV[k]) mBusy[waV[k*AW +: AW]] = 1'b0;
      if (alV && aaV != 0) mBusy[aaV] = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         for (int i = 0; i < NR; i++) begin
            checkOutput($sformatf("rdata%0d", i), 64'(rdata[i*DW +: DW]), 64'(e.rdata[i*DW +: DW]));
            checkOutput($sformatf("rbusy%0d", i), 64'(rbusy[i]), 64'(e.rbusy[i]));
         end
         checkOutput("busy_vec", 64'(busyVec), 64'(e.busyVec));
      end
   end

   function automatic logic [AW-1:0] randAddr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
      return AW'($urandom_range(0, 7));
   endfunction

   initial begin
      int guard;
      rst_n = 1'b0;
      we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
      allocEn = 1'b0; allocAddr = '0; flush = 1'b0;
      modelReset();
      #12;
      checkOutput("reset_busy_vec", 64'(busyVec), 64'h0);
      checkOutput("reset_rdata", 64'(rdata), 64'h0);
      rst_n = 1'b1;

      // Write r5, then assert reset mid-cycle while a bypassing write is pending.
      applyStimulus(2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 2'b01, {5'd0, 5'd5}, 1'b0, 5'd0, 1'b0);
      applyStimulus(2'b00, '0, '0, 2'b11, {5'd5, 5'd5}, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      #2;
      we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hCAFEF00D};
      allocEn = 1'b1; allocAddr = 5'd5;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_rdata", 64'(rdata), 64'h0);
      checkOutput("rst_rbusy", 64'(rbusy), 64'h0);
      checkOutput("rst_busy_vec", 64'(busyVec), 64'h0);
      modelReset();
      @(posedge clk);
      #1;
      we = '0; allocEn = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      checkOutput("post_rst_r5", 64'(rdata[DW-1:0]), 64'h0);
      applyStimulus(2'b00, '0, '0, 2'b01, {5'd0, 5'd5}, 1'b0, 5'd0, 1'b0);

      // Zero register.
      applyStimulus(2'b01, {5'd0, 5'd0}, {32'h0, 32'hFFFFFFFF}, 2'b01, {5'd0, 5'd0}, 1'b1, 5'd0, 1'b0);
      applyStimulus(2'b00, '0, '0, 2'b11, {5'd0, 5'd0}, 1'b0, 5'd0, 1'b0);

      // Same-address write conflict and bypass priority.
      applyStimulus(2'b11, {5'd7, 5'd7}, {32'h22222222, 32'h11111111}, 2'b11, {5'd7, 5'd7}, 1'b0, 5'd0, 1'b0);
      applyStimulus(2'b00, '0, '0, 2'b11, {5'd7, 5'd7}, 1'b0, 5'd0, 1'b0);
      #2;
      checkOutput("r7_priority", 64'(rdata[DW-1:0]), 64'h22222222);

      // Scoreboard lifetime of r9.
      applyStimulus(2'b00, '0, '0, 2'b01, {5'd0, 5'd9}, 1'b1, 5'd9, 1'b0);
      applyStimulus(2'b00, '0, '0, 2'b01, {5'd0, 5'd9}, 1'b0, 5'd0, 1'b0);
      #2;
      checkOutput("r9_busy", 64'(rbusy[0]), 64'h1);
      applyStimulus(2'b00, '0, '0, 2'b01, {5'd0, 5'd9}, 1'b0, 5'd0, 1'b0);
      applyStimulus(2'b10, {5'd9, 5'd0}, {32'h00001234, 32'h0}, 2'b01, {5'd0, 5'd9}, 1'b0, 5'd0, 1'b0);
      applyStimulus(2'b00, '0, '0, 2'b10, {5'd9, 5'd0}, 1'b0, 5'd0, 1'b0);

      // Allocation beats a same-edge write to the same register.
      applyStimulus(2'b00, '0, '0, 2'b00, '0, 1'b1, 5'd4, 1'b0);
      applyStimulus(2'b01, {5'd0, 5'd4}, {32'h0, 32'h0000ABCD}, 2'b00, '0, 1'b1, 5'd4, 1'b0);
      applyStimulus(2'b00, '0, '0, 2'b01, {5'd0, 5'd4}, 1'b0, 5'd0, 1'b0);
      #2;
      checkOutput("r4_collide", {31'h0, rbusy[0], rdata[DW-1:0]}, {31'h0, 1'b1, 32'h0000ABCD});

      // Flush with a same-cycle allocation.
      applyStimulus(2'b00, '0, '0, 2'b00, '0, 1'b1, 5'd3, 1'b0);
      applyStimulus(2'b00, '0, '0, 2'b00, '0, 1'b1, 5'd6, 1'b0);
      applyStimulus(2'b00, '0, '0, 2'b00, '0, 1'b1, 5'd10, 1'b0);
      applyStimulus(2'b00, '0, '0, 2'b00, '0, 1'b1, 5'd12, 1'b1);
      applyStimulus(2'b00, '0, '0, 2'b11, {5'd6, 5'd3}, 1'b0, 5'd0, 1'b0);
      #2;
      checkOutput("flush_busy_vec", 64'(busyVec), 64'h00001000);
      applyStimulus(2'b00, '0, '0, 2'b11, {5'd12, 5'd10}, 1'b0, 5'd0, 1'b0);

      for (int n = 0; n < 400; n++) begin
         applyStimulus(NW'($urandom_range(0, 3)), {randAddr(), randAddr()},
                       {32'($urandom), 32'($urandom)}, NR'($urandom_range(0, 3)),
                       {randAddr(), randAddr()}, ($urandom_range(0, 2) == 0), randAddr(),
                       ($urandom_range(0, 15) == 0));
      end

      guard = 0;
      while (expQ.size() != 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      #1;
      if (expQ.size() != 0) begin
         nFail++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
